// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD add/subtract sequencer.
package bcd_pkg;

    localparam int          BCD_W    = 4;
    localparam logic [3:0]  BCD_NINE = 4'd9;
    localparam logic [3:0]  BCD_SIX  = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_serial_addsub_ctrl_if.sv
// Operand request / result handshake bundle for the serial BCD add/subtract block.
interface bcd_serial_addsub_ctrl_if #(
    parameter int NDIG = 4
);

    logic                in_valid;
    logic                in_ready;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                sub;
    logic                out_valid;
    logic                out_ready;
    logic [4*NDIG-1:0]   sum;
    logic                cout;
    logic                bcd_err;

    // Requester side: supplies operands, consumes the result.
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, bcd_err
    );

    // Sequencer side.
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, bcd_err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary add of two digits plus carry, then +6 decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic             cin,
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    output logic [BCD_W-1:0] s,
    output logic             cout
);

    logic [BCD_W:0] raw;
    logic           corr;

    // Binary sum, then correct by +6 whenever the raw sum exceeds 9.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        raw  = '0;
        corr = 1'b0;
        s    = '0;
        raw  = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, cin};
        corr = raw[BCD_W] | (raw[3] & raw[2]) | (raw[3] & raw[1]);
        s    = corr ? (raw[BCD_W-1:0] + BCD_SIX) : raw[BCD_W-1:0];
    end

    assign cout = corr;

endmodule

// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial packed-BCD add/subtract sequencer around one shared single-digit BCD adder.
module bcd_serial_addsub_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
)(
    input  logic                       clk,
    input  logic                       rst_n,
    bcd_serial_addsub_ctrl_if.slave    bus
);

    localparam int             W    = BCD_W * NDIG;
    localparam int             CW   = $clog2(NDIG) + 1;
    localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-1:0]       res_sh;
    logic               sub_r;
    logic               carry_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [W-1:0]       sum_r;
    logic               cout_r;
    logic               bcd_err_r;

    logic [BCD_W-1:0]   y_dig;
    logic [BCD_W-1:0]   d_sum;
    logic               d_cout;
    logic [W-1:0]       res_next;
    logic               err_in;

    // Operand B digit, replaced by its 9's complement when subtracting.
    always_comb begin
        y_dig = sub_r ? (BCD_NINE - b_sh[BCD_W-1:0]) : b_sh[BCD_W-1:0];
    end

    bcd_digit_add u_digit_add (
        .cin  (carry_r),
        .x    (a_sh[BCD_W-1:0]),
        .y    (y_dig),
        .s    (d_sum),
        .cout (d_cout)
    );

    // New digit enters the result at the most-significant end; after NDIG shifts digit 0 sits at the bottom.
    always_comb begin
        res_next = (res_sh >> BCD_W) | (W'(d_sum) << (W - BCD_W));
    end

    // Flag any operand digit above 9 at the moment of acceptance.
    always_comb begin
        err_in = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if ((bus.a[BCD_W*i +: BCD_W] > BCD_NINE) || (bus.b[BCD_W*i +: BCD_W] > BCD_NINE)) begin
                err_in = 1'b1;
            end
        end
    end

    // Sequencer: accept operands, run one digit per cycle LSD first, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            sub_r       <= 1'b0;
            carry_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            bcd_err_r   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_sh       <= bus.a;
                        b_sh       <= bus.b;
                        sub_r      <= bus.sub;
                        carry_r    <= bus.sub;
                        cnt        <= '0;
                        bcd_err_r  <= err_in;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> BCD_W;
                    b_sh    <= b_sh >> BCD_W;
                    res_sh  <= res_next;
                    carry_r <= d_cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_r  <= res_next;
                        cout_r <= d_cout;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid_r && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.bcd_err   = bcd_err_r;

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Directed bench for the serial BCD add/subtract sequencer (NDIG=4).
module tb_bcd_serial_addsub_ctrl;

    localparam int NDIG = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bcd_serial_addsub_ctrl_if #(.NDIG(NDIG)) bus ();

    bcd_serial_addsub_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one operand pair; returns one ns after the accepting edge.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic s);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_op", bus.in_ready, 1);
        bus.a        = av;
        bus.b        = bv;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid shows up (bounded).
    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, NDIG + 1);
    endtask

    task automatic take_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, bus.out_valid, 0);
        check({tag, "_in_ready_back"}, bus.in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic s, input logic [15:0] exp_sum, input logic exp_cout);
        start_op(av, bv, s);
        check({tag, "_in_ready_busy"}, bus.in_ready, 0);
        wait_result(tag);
        check({tag, "_sum"}, bus.sum, exp_sum);
        check({tag, "_cout"}, bus.cout, exp_cout);
        check({tag, "_bcd_err"}, bus.bcd_err, 0);
        take_result(tag);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;

        #22;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_bcd_err", bus.bcd_err, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain add, no carry out.
        run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0);
        // Carry ripples through every digit.
        run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1);
        // Subtract without borrow.
        run_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1);
        // Subtract with borrow: raw 10's complement result.
        run_op("sub_0001_0002", 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0);

        // Invalid digit in A raises bcd_err alongside out_valid.
        start_op(16'h12A4, 16'h0000, 1'b0);
        wait_result("bad_digit");
        check("bad_digit_bcd_err", bus.bcd_err, 1);
        take_result("bad_digit");
        run_op("add_0000_0000", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Result held while the consumer stalls; new requests are refused.
        start_op(16'h9999, 16'h9999, 1'b0);
        wait_result("stall");
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_sum", bus.sum, 16'h9998);
            check("stall_cout", bus.cout, 1);
            check("stall_in_ready", bus.in_ready, 0);
        end
        take_result("stall");
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("stall_no_accept_sum", bus.sum, 16'h9998);
        check("stall_no_accept_in_ready", bus.in_ready, 1);

        // Asynchronous reset in the middle of digit 2.
        start_op(16'h4321, 16'h1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", bus.in_ready, 1);
        check("midrun_rst_out_valid", bus.out_valid, 0);
        check("midrun_rst_sum", bus.sum, 0);
        check("midrun_rst_cout", bus.cout, 0);
        check("midrun_rst_bcd_err", bus.bcd_err, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst_0010_0020", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
